// File: rtl/position_calc.sv
// Delta-over-sigma X/Y/(optional Q) position from four trimmed button magnitudes; Q divider built when POSITION_CALC_Q_EN is defined.
// Latency: result toggle flips POS_WIDTH+1 edges after capture. Input sets that arrive while busy are dropped and counted.
module position_calc #(
    parameter int MAG_WIDTH = 26,
    parameter int POS_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   trimmedToggle,
    input  logic [4*MAG_WIDTH-1:0] trimmed,
    input  logic                   overrunClear,
    output logic                   positionToggle,
    output logic [POS_WIDTH-1:0]   xPos,
    output logic [POS_WIDTH-1:0]   yPos,
    output logic [POS_WIDTH-1:0]   qPos,
    output logic [MAG_WIDTH+1:0]   sum,
    output logic                   sumZero,
    output logic                   busy,
    output logic [7:0]             overrunCount
);

    localparam int SW = MAG_WIDTH + 2;
    localparam int FW = POS_WIDTH - 1;
    localparam int CW = $clog2(POS_WIDTH);
`ifdef POSITION_CALC_Q_EN
    localparam int ND = 3;
`else
    localparam int ND = 2;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_SUM, ST_DIVIDE, ST_FINISH} state_t;

    state_t                 state_q, state_d;
    logic                   shadow_q, shadow_d;
    logic                   primed_q, primed_d;
    logic [MAG_WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [SW-1:0]          s_q, s_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          rem_q [ND];
    logic [SW-1:0]          rem_d [ND];
    logic [FW-1:0]          quot_q [ND];
    logic [FW-1:0]          quot_d [ND];
    logic                   neg_q [ND];
    logic                   neg_d [ND];
    logic [POS_WIDTH-1:0]   pos_q [ND];
    logic [POS_WIDTH-1:0]   pos_d [ND];
    logic [SW-1:0]          sum_q, sum_d;
    logic                   sum_zero_q, sum_zero_d;
    logic                   ptog_q, ptog_d;
    logic [7:0]             ovr_q, ovr_d;

    logic                   evt;
    logic [SW-1:0]          a_ext, b_ext, c_ext, d_ext;
    logic [SW-1:0]          delta_c [ND];
    logic [SW-1:0]          abs_c [ND];
    logic [SW:0]            step_c [ND];

    // One restoring step; remainder never exceeds S, so 2r-S always fits SW bits.
    // S == 0 forces zero quotient bits so an all-zero set reads as position 0.
    function automatic logic [SW:0] div_step(input logic [SW-1:0] r, input logic [SW-1:0] s);
        logic [SW:0] r2;
        r2 = {r, 1'b0};
        if (s != '0 && r2 >= {1'b0, s})
            div_step = {1'b1, r2[SW-1:0] - s};
        else
            div_step = {1'b0, r2[SW-1:0]};
    endfunction

    assign evt   = primed_q && (trimmedToggle != shadow_q);
    assign a_ext = SW'(a_q);
    assign b_ext = SW'(b_q);
    assign c_ext = SW'(c_q);
    assign d_ext = SW'(d_q);

    always_comb begin
        delta_c[0] = (a_ext + d_ext) - (b_ext + c_ext);
        delta_c[1] = (a_ext + b_ext) - (c_ext + d_ext);
`ifdef POSITION_CALC_Q_EN
        delta_c[2] = (a_ext + c_ext) - (b_ext + d_ext);
`endif
        for (int i = 0; i < ND; i++) begin
            abs_c[i]  = delta_c[i][SW-1] ? -delta_c[i] : delta_c[i];
            step_c[i] = div_step(rem_q[i], s_q);
        end
    end

    always_comb begin
        state_d    = state_q;
        shadow_d   = trimmedToggle;
        primed_d   = 1'b1;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        d_d        = d_q;
        s_d        = s_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        neg_d      = neg_q;
        pos_d      = pos_q;
        sum_d      = sum_q;
        sum_zero_d = sum_zero_q;
        ptog_d     = ptog_q;
        ovr_d      = ovr_q;

        case (state_q)
            ST_IDLE: begin
                if (evt) begin
                    a_d     = trimmed[0*MAG_WIDTH +: MAG_WIDTH];
                    b_d     = trimmed[1*MAG_WIDTH +: MAG_WIDTH];
                    c_d     = trimmed[2*MAG_WIDTH +: MAG_WIDTH];
                    d_d     = trimmed[3*MAG_WIDTH +: MAG_WIDTH];
                    state_d = ST_SUM;
                end
            end
            ST_SUM: begin
                s_d = a_ext + b_ext + c_ext + d_ext;
                for (int i = 0; i < ND; i++) begin
                    neg_d[i]  = delta_c[i][SW-1];
                    rem_d[i]  = abs_c[i];
                    quot_d[i] = '0;
                end
                cnt_d   = CW'(FW);
                state_d = ST_DIVIDE;
            end
            ST_DIVIDE: begin
                for (int i = 0; i < ND; i++) begin
                    rem_d[i]  = step_c[i][SW-1:0];
                    quot_d[i] = {quot_q[i][FW-2:0], step_c[i][SW]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1))
                    state_d = ST_FINISH;
            end
            ST_FINISH: begin
                for (int i = 0; i < ND; i++)
                    pos_d[i] = neg_q[i] ? -{1'b0, quot_q[i]} : {1'b0, quot_q[i]};
                sum_d      = s_q;
                sum_zero_d = (s_q == '0);
                ptog_d     = ~ptog_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A clear coinciding with a drop still records that drop.
        if (overrunClear)
            ovr_d = (evt && state_q != ST_IDLE) ? 8'd1 : 8'd0;
        else if (evt && state_q != ST_IDLE && ovr_q != 8'hFF)
            ovr_d = ovr_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shadow_q   <= 1'b0;
            primed_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            s_q        <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            sum_zero_q <= 1'b0;
            ptog_q     <= 1'b0;
            ovr_q      <= '0;
            for (int i = 0; i < ND; i++) begin
                rem_q[i]  <= '0;
                quot_q[i] <= '0;
                neg_q[i]  <= 1'b0;
                pos_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            primed_q   <= primed_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
            s_q        <= s_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            sum_zero_q <= sum_zero_d;
            ptog_q     <= ptog_d;
            ovr_q      <= ovr_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            neg_q      <= neg_d;
            pos_q      <= pos_d;
        end
    end

    assign positionToggle = ptog_q;
    assign xPos           = pos_q[0];
    assign yPos           = pos_q[1];
`ifdef POSITION_CALC_Q_EN
    assign qPos           = pos_q[2];
`else
    assign qPos           = '0;
`endif
    assign sum            = sum_q;
    assign sumZero        = sum_zero_q;
    assign busy           = (state_q != ST_IDLE);
    assign overrunCount   = ovr_q;

endmodule

// File: tb/tb_position_calc.sv
// Randomized and directed bench for position_calc against a delta-over-sigma arithmetic model.
module tb_position_calc;
    localparam int MW = 26;
    localparam int PW = 24;
    localparam int LAT = PW + 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               trimmedToggle = 1'b0;
    logic [4*MW-1:0]    trimmed = '0;
    logic               overrunClear = 1'b0;
    logic               positionToggle;
    logic [PW-1:0]      xPos, yPos, qPos;
    logic [MW+1:0]      sum;
    logic               sumZero, busy;
    logic [7:0]         overrunCount;

    int checks = 0;
    int errors = 0;

    position_calc #(.MAG_WIDTH(MW), .POS_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n), .trimmedToggle(trimmedToggle), .trimmed(trimmed),
        .overrunClear(overrunClear), .positionToggle(positionToggle), .xPos(xPos),
        .yPos(yPos), .qPos(qPos), .sum(sum), .sumZero(sumZero), .busy(busy),
        .overrunCount(overrunCount)
    );

    always #5 clk = ~clk;

    // delta/S as a signed fraction with PW-1 fraction bits, truncated toward zero
    function automatic logic [PW-1:0] ref_pos(input longint delta, input longint s);
        longint m, q;
        m = (delta < 0) ? -delta : delta;
        if (s == 0)      q = 0;
        else if (m >= s) q = (longint'(1) << (PW-1)) - 1;
        else             q = (m << (PW-1)) / s;
        if (delta < 0) q = -q;
        return q[PW-1:0];
    endfunction

    logic [PW-1:0] ex, ey, eq;
    logic [MW+1:0] es;
    logic          ez;

    task automatic model(input longint a, input longint b, input longint c, input longint d);
        longint s;
        s  = a + b + c + d;
        es = s[MW+1:0];
        ez = (s == 0);
        ex = ref_pos((a + d) - (b + c), s);
        ey = ref_pos((a + b) - (c + d), s);
`ifdef POSITION_CALC_Q_EN
        eq = ref_pos((a + c) - (b + d), s);
`else
        eq = '0;
`endif
    endtask

    task automatic launch(input logic [MW-1:0] a, input logic [MW-1:0] b,
                          input logic [MW-1:0] c, input logic [MW-1:0] d);
        @(negedge clk);
        trimmed       = {d, c, b, a};
        trimmedToggle = ~trimmedToggle;
    endtask

    // Counts posedges from launch until positionToggle changes; -1 if it never does.
    task automatic wait_result(output int lat, output logic busy_mid);
        logic old;
        old = positionToggle;
        lat = -1;
        busy_mid = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (n == 2) busy_mid = busy;
            if (positionToggle !== old) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({positionToggle, xPos, yPos, qPos, sum, sumZero, busy, overrunCount} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got tog=%b x=%h y=%h q=%h s=%h z=%b busy=%b ovr=%0d, want all 0",
                     positionToggle, xPos, yPos, qPos, sum, sumZero, busy, overrunCount);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_and_check(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b,
                                 input logic [MW-1:0] c, input logic [MW-1:0] d);
        int lat;
        logic bm;
        model(a, b, c, d);
        launch(a, b, c, d);
        wait_result(lat, bm);
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, want %0d", tag, lat, LAT);
        end
        checks++;
        if (bm !== 1'b1) begin errors++; $display("FAIL %s busy_mid: got %b want 1", tag, bm); end
        checks++;
        if (xPos !== ex) begin errors++; $display("FAIL %s xPos: got %h want %h", tag, xPos, ex); end
        checks++;
        if (yPos !== ey) begin errors++; $display("FAIL %s yPos: got %h want %h", tag, yPos, ey); end
        checks++;
        if (qPos !== eq) begin errors++; $display("FAIL %s qPos: got %h want %h", tag, qPos, eq); end
        checks++;
        if (sum !== es || sumZero !== ez) begin
            errors++;
            $display("FAIL %s sum: got %0d/%b want %0d/%b", tag, sum, sumZero, es, ez);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_end: got %b want 0", tag, busy); end
    endtask

    task automatic test_directed;
        logic [MW-1:0] va [8] = '{26'd1000, 26'd3000, 26'd0,    26'd0, 26'd7, 26'd0, 26'h3FFFFFF, 26'd1};
        logic [MW-1:0] vb [8] = '{26'd1000, 26'd1000, 26'd5000, 26'd0, 26'd0, 26'd0, 26'h3FFFFFF, 26'd2};
        logic [MW-1:0] vc [8] = '{26'd1000, 26'd1000, 26'd5000, 26'd0, 26'd0, 26'd0, 26'h3FFFFFF, 26'd0};
        logic [MW-1:0] vd [8] = '{26'd1000, 26'd3000, 26'd0,    26'd0, 26'd0, 26'h3FFFFFF, 26'h3FFFFFF, 26'd0};
        for (int i = 0; i < 8; i++)
            run_and_check($sformatf("dir%0d", i), va[i], vb[i], vc[i], vd[i]);
        // independent constants for the headline vectors
        run_and_check("half", 26'd3000, 26'd1000, 26'd1000, 26'd3000);
        checks++;
        if (xPos !== 24'd4194304 || sum !== 28'd8000) begin
            errors++;
            $display("FAIL half_const: got x=%0d s=%0d want 4194304 8000", xPos, sum);
        end
        run_and_check("negsat", 26'd0, 26'd5000, 26'd5000, 26'd0);
        checks++;
        if (xPos !== 24'h800001) begin
            errors++;
            $display("FAIL negsat_const: got x=%h want 800001", xPos);
        end
    endtask

    task automatic test_random;
        logic [MW-1:0] r [4];
        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < 4; k++)
                r[k] = (i % 3 == 0) ? MW'($urandom_range(0, 20)) : MW'($urandom);
            run_and_check($sformatf("rnd%0d", i), r[0], r[1], r[2], r[3]);
        end
    endtask

    task automatic test_overrun;
        logic old;
        int lat, extra;
        model(26'd3000, 26'd1000, 26'd1000, 26'd3000);
        old = positionToggle;
        lat = -1;
        launch(26'd3000, 26'd1000, 26'd1000, 26'd3000);
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (n == 10) begin
                trimmed       = {26'd9, 26'd500, 26'd70, 26'd4};
                trimmedToggle = ~trimmedToggle;
            end
            if (positionToggle !== old) begin lat = n; break; end
        end
        checks++;
        if (lat != LAT || xPos !== ex || sum !== es) begin
            errors++;
            $display("FAIL ovr_first: got lat=%0d x=%h s=%0d want %0d %h %0d", lat, xPos, sum, LAT, ex, es);
        end
        extra = 0;
        old = positionToggle;
        repeat (40) begin
            @(posedge clk); #1;
            if (positionToggle !== old || busy) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL ovr_noextra: got %0d busy/flip cycles want 0", extra); end
        checks++;
        if (overrunCount !== 8'd1) begin errors++; $display("FAIL ovr_count1: got %0d want 1", overrunCount); end
        @(negedge clk) overrunClear = 1'b1;
        @(negedge clk) overrunClear = 1'b0;
        checks++;
        if (overrunCount !== 8'd0) begin errors++; $display("FAIL ovr_clear: got %0d want 0", overrunCount); end
        // flip every cycle: far more than 255 sets land while busy
        trimmed = {26'd1000, 26'd1000, 26'd1000, 26'd3000};
        repeat (400) @(negedge clk) trimmedToggle = ~trimmedToggle;
        for (int n = 0; n < 60 && busy; n++) @(negedge clk);
        checks++;
        if (overrunCount !== 8'd255 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovr_sat: got %0d busy=%b want 255 0", overrunCount, busy);
        end
        launch(26'd3000, 26'd1000, 26'd1000, 26'd3000);
        repeat (5) @(negedge clk);
        overrunClear  = 1'b1;
        trimmedToggle = ~trimmedToggle;
        @(negedge clk) overrunClear = 1'b0;
        checks++;
        if (overrunCount !== 8'd1) begin errors++; $display("FAIL ovr_clear_hit: got %0d want 1", overrunCount); end
        for (int n = 0; n < 60 && busy; n++) @(negedge clk);
    endtask

    task automatic test_reset_midop;
        int spurious;
        run_and_check("pre_rst", 26'd3000, 26'd1000, 26'd1000, 26'd3000);
        launch(26'd100, 26'd200, 26'd300, 26'd400);
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({positionToggle, xPos, yPos, qPos, sum, sumZero, busy, overrunCount} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got tog=%b x=%h y=%h s=%h busy=%b ovr=%0d want all 0",
                     positionToggle, xPos, yPos, sum, busy, overrunCount);
        end
        trimmedToggle = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        spurious = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (positionToggle !== 1'b0 || busy) spurious++;
        end
        checks++;
        if (spurious != 0) begin errors++; $display("FAIL midrst_prime: got %0d active cycles want 0", spurious); end
        run_and_check("post_rst", 26'd0, 26'd5000, 26'd5000, 26'd0);
        checks++;
        if (positionToggle !== 1'b1) begin errors++; $display("FAIL post_rst_tog: got %b want 1", positionToggle); end
    endtask

    initial begin
        #3;
        test_reset;
        test_directed;
        test_random;
        test_overrun;
        test_reset_midop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/position_calc.md
Name: position_calc

Overview:
- Downstream consumer of the gain-trim stage.
- Takes four trimmed button magnitudes (A, B, C, D) and the trim stage's result toggle.
- Forms sum and difference terms, then runs three restoring dividers in parallel to produce normalized delta-over-sigma X, Y and Q (skew) positions.
- Publishes the results with its own toggle for the downstream readout/averaging logic.

Parameters:
- MAG_WIDTH, 26, width of each unsigned trimmed magnitude.
- POS_WIDTH, 24, width of each signed position output; fraction bits = POS_WIDTH-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- trimmedToggle  input  1  flips once per new trimmed set; same clock domain.
- trimmed  input  4*MAG_WIDTH  magnitudes; A = bits [MAG_WIDTH-1:0], then B, C, D.
- overrunClear  input  1  synchronous clear of overrunCount.
- positionToggle  output  1  flips when new positions are valid.
- xPos  output  POS_WIDTH  signed, ((A+D)-(B+C))/S scaled by 2^(POS_WIDTH-1).
- yPos  output  POS_WIDTH  signed, ((A+B)-(C+D))/S scaled likewise.
- qPos  output  POS_WIDTH  signed, ((A+C)-(B+D))/S scaled likewise.
- sum  output  MAG_WIDTH+2  S = A+B+C+D.
- sumZero  output  1  S was zero for the current result.
- busy  output  1  high whenever state is not IDLE.
- overrunCount  output  8  count of dropped input sets, saturating.

Behaviour:
- Reset (asynchronous): every output 0, state IDLE, toggle shadow 0, primed 0.
- Priming: the first clk edge after reset release loads the shadow from trimmedToggle and sets primed. No event is generated on that edge.
- Event detection: an event occurs when primed and trimmedToggle differs from the shadow. The shadow updates every cycle.
- IDLE: on an event, capture trimmed into A..D; go to SUM.
- SUM (1 cycle):
  - Register S (MAG_WIDTH+2 bits).
  - Register the absolute value and sign of each delta. Deltas are computed as signed MAG_WIDTH+2 bits.
  - Load each remainder with its |delta|.
  - Load the bit counter with POS_WIDTH-1; go to DIVIDE.
- DIVIDE (POS_WIDTH-1 cycles), per step and per divider:
  - r <= 2r.
  - If 2r >= S, then r <= 2r-S and the quotient bit is 1; otherwise the bit is 0.
  - Quotient bits are shifted in MSB first.
  - Go to FINISH when the counter expires.
- FINISH (1 cycle):
  - Each position = {0, quotient}, negated if the delta sign is negative.
  - Update xPos/yPos/qPos/sum/sumZero together and flip positionToggle; return to IDLE.
- Latency: positionToggle flips on capture edge + POS_WIDTH+1 edges (25 for the default).
- Rounding: truncation toward zero.
- |delta| == S yields the magnitude 2^(POS_WIDTH-1)-1. This is inherent saturation; no explicit clamp.
- S == 0: all remainders are 0, so positions are 0 and sumZero = 1.
- Outputs hold their values between results. A partial result is never visible.
- Overrun:
  - An event while not IDLE is dropped and overrunCount increments, saturating at 255.
  - The active computation continues unaffected.
  - If overrunClear and an overrun occur in the same cycle, the count becomes 1.
- Reset mid-operation aborts the computation immediately. positionToggle returns to 0 and priming is repeated after release.

Optional Feature:
- Macro: POSITION_CALC_Q_EN.
- Defined: the Q difference and the third divider are built; qPos is as specified above.
- Undefined: the Q difference and divider are omitted; qPos is held at 0. Latency and all other outputs are unchanged.

Test Plan:
- A=B=C=D=1000, toggle flip -> after 25 cycles positionToggle=1, xPos=yPos=qPos=0, sum=4000, sumZero=0.
- A=D=3000, B=C=1000 -> xPos=4194304 (0.5), yPos=0, qPos=0, sum=8000.
- A=D=0, B=C=5000 -> xPos=-8388607 (0x800001), yPos=0, qPos=0, sum=10000.
- All magnitudes 0 -> positions 0, sum=0, sumZero=1, toggle still flips.
- Overrun sequence:
  - Stimulus: two toggle flips 10 cycles apart.
  - Response: exactly one positionToggle flip (for the first set) and overrunCount=1.
  - Then pulse overrunClear -> overrunCount=0.
  - Then 300 overruns -> overrunCount=255.
- Reset handling:
  - Assert rst_n low at DIVIDE cycle 10 -> all outputs 0 asynchronously, state IDLE.
  - Release with trimmedToggle=1 -> no spurious result.
  - The next flip produces a normal result.
